// File: rtl/cr_clic_pkg.sv
// Shared definitions for the CLIC interrupt request stage: FSM state encoding
// and default sizing constants.
package cr_clic_pkg;

    localparam int CLIC_INT_NUM_DEF    = 32;
    localparam int CLIC_PRIO_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CLR  = 2'd2
    } clic_req_state_e;

endpackage

// File: rtl/cr_clic_onehot_enc.sv
// One-hot to binary encoder built purely from OR terms; a zero input gives 0.
module cr_clic_onehot_enc
    import cr_clic_pkg::*;
#(
    parameter int INT_NUM  = CLIC_INT_NUM_DEF,
    parameter int ID_WIDTH = 5
) (
    input  logic [INT_NUM-1:0]  onehot,
    output logic [ID_WIDTH-1:0] bin
);

    logic [ID_WIDTH-1:0] bin_s;

    // OR together the index of every set bit; with a one-hot input this is the index
    always_comb begin
        bin_s = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            bin_s = bin_s | (ID_WIDTH'(i) & {ID_WIDTH{onehot[i]}});
        end
    end

    assign bin = bin_s;

endmodule

// File: rtl/cr_clic_int_req.sv
// CLIC request stage: turns the arbitration winner into a held core request and
// issues a one-cycle pending-clear on acceptance. Macro CR_CLIC_REQ_PREEMPT_EN enables preemption.
module cr_clic_int_req
    import cr_clic_pkg::*;
#(
    parameter int INT_NUM    = CLIC_INT_NUM_DEF,
    parameter int PRIO_WIDTH = CLIC_PRIO_WIDTH_DEF,
    parameter int ID_WIDTH   = 5
) (
    input  logic                          clic_clk,
    input  logic                          clic_rst,
    input  logic [INT_NUM-1:0]            sel_onehot,
    input  logic [PRIO_WIDTH*INT_NUM-1:0] prio_in_vec,
    input  logic [PRIO_WIDTH-1:0]         int_thresh,
    input  logic                          core_int_ack,
    output logic                          clic_int_vld,
    output logic [ID_WIDTH-1:0]           clic_int_id,
    output logic [PRIO_WIDTH-1:0]         clic_int_prio,
    output logic [INT_NUM-1:0]            pend_clr_onehot
);

    logic [ID_WIDTH-1:0]   cand_id_s;
    logic [PRIO_WIDTH-1:0] cand_prio_s;
    logic                  cand_vld_s;

    clic_req_state_e       state_r;
    logic                  vld_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic [PRIO_WIDTH-1:0] prio_r;
    logic [INT_NUM-1:0]    clr_r;

    cr_clic_onehot_enc #(
        .INT_NUM  (INT_NUM),
        .ID_WIDTH (ID_WIDTH)
    ) u_cand_enc (
        .onehot (sel_onehot),
        .bin    (cand_id_s)
    );

    // Priority of the winning source; a priority of 0 means the source is not pending
    always_comb begin
        cand_prio_s = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            cand_prio_s = cand_prio_s |
                (prio_in_vec[i*PRIO_WIDTH +: PRIO_WIDTH] & {PRIO_WIDTH{sel_onehot[i]}});
        end
        cand_vld_s = (|sel_onehot) && (cand_prio_s != '0) && (cand_prio_s > int_thresh);
    end

    // Request FSM with all outputs registered; an ack in REQ outranks every other event
    always_ff @(posedge clic_clk) begin
        if (clic_rst) begin
            state_r <= ST_IDLE;
            vld_r   <= 1'b0;
            id_r    <= '0;
            prio_r  <= '0;
            clr_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clr_r <= '0;
                    if (cand_vld_s) begin
                        state_r <= ST_REQ;
                        vld_r   <= 1'b1;
                        id_r    <= cand_id_s;
                        prio_r  <= cand_prio_s;
                    end else begin
                        state_r <= ST_IDLE;
                        vld_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (core_int_ack) begin
                        state_r <= ST_CLR;
                        vld_r   <= 1'b0;
                        clr_r   <= {{(INT_NUM-1){1'b0}}, 1'b1} << id_r;
                    end else if (!cand_vld_s) begin
                        state_r <= ST_IDLE;
                        vld_r   <= 1'b0;
                        clr_r   <= '0;
`ifdef CR_CLIC_REQ_PREEMPT_EN
                    end else if (cand_prio_s > prio_r) begin
                        state_r <= ST_REQ;
                        vld_r   <= 1'b1;
                        id_r    <= cand_id_s;
                        prio_r  <= cand_prio_s;
                        clr_r   <= '0;
`endif
                    end else begin
                        state_r <= ST_REQ;
                        vld_r   <= 1'b1;
                        clr_r   <= '0;
                    end
                end
                ST_CLR: begin
                    // One idle cycle so the clear reaches the pending bits before re-arbitration
                    state_r <= ST_IDLE;
                    vld_r   <= 1'b0;
                    clr_r   <= '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    vld_r   <= 1'b0;
                    clr_r   <= '0;
                end
            endcase
        end
    end

    assign clic_int_vld    = vld_r;
    assign clic_int_id     = id_r;
    assign clic_int_prio   = prio_r;
    assign pend_clr_onehot = clr_r;

endmodule

// File: tb/tb_cr_clic_int_req.sv
// Bench for cr_clic_int_req: directed vector table followed by randomized
// stimulus against a rule-level reference model.
module tb_cr_clic_int_req;

    localparam int N  = 32;
    localparam int PW = 6;
    localparam int IW = 5;

    logic            clic_clk;
    logic            clic_rst;
    logic [N-1:0]    sel_onehot;
    logic [PW*N-1:0] prio_in_vec;
    logic [PW-1:0]   int_thresh;
    logic            core_int_ack;
    logic            clic_int_vld;
    logic [IW-1:0]   clic_int_id;
    logic [PW-1:0]   clic_int_prio;
    logic [N-1:0]    pend_clr_onehot;

    int n_checks = 0;
    int n_errors = 0;

    cr_clic_int_req #(.INT_NUM(N), .PRIO_WIDTH(PW), .ID_WIDTH(IW)) dut (
        .clic_clk        (clic_clk),
        .clic_rst        (clic_rst),
        .sel_onehot      (sel_onehot),
        .prio_in_vec     (prio_in_vec),
        .int_thresh      (int_thresh),
        .core_int_ack    (core_int_ack),
        .clic_int_vld    (clic_int_vld),
        .clic_int_id     (clic_int_id),
        .clic_int_prio   (clic_int_prio),
        .pend_clr_onehot (pend_clr_onehot)
    );

    initial clic_clk = 1'b0;
    always #5 clic_clk = ~clic_clk;

    typedef struct {
        logic          rst;
        logic [N-1:0]  sel;
        int            pidx;
        logic [PW-1:0] pval;
        logic [PW-1:0] thr;
        logic          ack;
        logic          ev;
        logic [IW-1:0] eid;
        logic [PW-1:0] ep;
        logic [N-1:0]  eclr;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl[NV];

`ifdef CR_CLIC_REQ_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    function automatic vec_t mk(logic rst, logic [N-1:0] sel, int pidx, int pval, int thr,
                                logic ack, logic ev, int eid, int ep, logic [N-1:0] eclr);
        vec_t v;
        v.rst = rst; v.sel = sel; v.pidx = pidx; v.pval = PW'(pval); v.thr = PW'(thr);
        v.ack = ack; v.ev = ev; v.eid = IW'(eid); v.ep = PW'(ep); v.eclr = eclr;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: what the outputs should be after the next edge
    logic          m_vld;
    logic [IW-1:0] m_id;
    logic [PW-1:0] m_prio;
    logic [N-1:0]  m_clr;

    task automatic model_step();
        bit            found = 1'b0;
        int            cid = 0;
        logic [PW-1:0] cp = '0;
        bit            cv;
        for (int i = 0; i < N; i++) begin
            if (sel_onehot[i]) begin
                found = 1'b1;
                cid = i;
                cp = prio_in_vec[i*PW +: PW];
            end
        end
        cv = found && (cp != 0) && (cp > int_thresh);
        if (clic_rst) begin
            m_vld = 1'b0; m_id = '0; m_prio = '0; m_clr = '0;
        end else if (m_clr != '0) begin
            m_clr = '0;
        end else if (m_vld && core_int_ack) begin
            m_clr = N'(1) << m_id;
            m_vld = 1'b0;
        end else if (m_vld && !cv) begin
            m_vld = 1'b0;
        end else if (m_vld) begin
            if (PREEMPT && cp > m_prio) begin
                m_id = IW'(cid);
                m_prio = cp;
            end
        end else if (cv) begin
            m_vld = 1'b1;
            m_id = IW'(cid);
            m_prio = cp;
        end
    endtask

    initial begin
        // Directed sequence, one entry per clock
        tbl[0]  = mk(1, 32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 32'h10, 4, 5, 2, 0, 1, 4, 5, 32'h0);
        tbl[2]  = mk(0, 32'h10, 4, 5, 2, 1, 0, 0, 0, 32'h10);
        tbl[3]  = mk(0, 32'h0,  0, 0, 2, 0, 0, 0, 0, 32'h0);
        tbl[4]  = mk(0, 32'h10, 4, 3, 3, 0, 0, 0, 0, 32'h0);
        tbl[5]  = mk(0, 32'h10, 4, 3, 3, 0, 0, 0, 0, 32'h0);
        tbl[6]  = mk(0, 32'h10, 4, 3, 2, 0, 1, 4, 3, 32'h0);
        tbl[7]  = mk(0, 32'h0,  0, 0, 2, 0, 0, 0, 0, 32'h0);
        tbl[8]  = mk(0, 32'h10, 4, 5, 2, 0, 1, 4, 5, 32'h0);
        if (PREEMPT) begin
            tbl[9]  = mk(0, 32'h80, 7, 9, 2, 0, 1, 7, 9, 32'h0);
            tbl[10] = mk(0, 32'h80, 7, 9, 2, 1, 0, 0, 0, 32'h80);
        end else begin
            tbl[9]  = mk(0, 32'h80, 7, 9, 2, 0, 1, 4, 5, 32'h0);
            tbl[10] = mk(0, 32'h80, 7, 9, 2, 1, 0, 0, 0, 32'h10);
        end
        tbl[11] = mk(0, 32'h0,  0, 0, 2, 0, 0, 0, 0, 32'h0);
        tbl[12] = mk(0, 32'h10, 4, 5, 2, 0, 1, 4, 5, 32'h0);
        tbl[13] = mk(0, 32'h04, 2, 3, 2, 0, 1, 4, 5, 32'h0);
        tbl[14] = mk(0, 32'h0,  0, 0, 2, 1, 0, 0, 0, 32'h10);
        tbl[15] = mk(0, 32'h0,  0, 0, 2, 0, 0, 0, 0, 32'h0);
        tbl[16] = mk(0, 32'h0,  0, 0, 2, 1, 0, 0, 0, 32'h0);
        tbl[17] = mk(0, 32'h10, 4, 5, 2, 0, 1, 4, 5, 32'h0);
        tbl[18] = mk(0, 32'h10, 4, 5, 5, 0, 0, 0, 0, 32'h0);
        tbl[19] = mk(0, 32'h10, 4, 5, 2, 0, 1, 4, 5, 32'h0);
        tbl[20] = mk(1, 32'h10, 4, 5, 2, 1, 0, 0, 0, 32'h0);
        tbl[21] = mk(0, 32'h0,  0, 0, 2, 0, 0, 0, 0, 32'h0);
        tbl[22] = mk(0, 32'h80000000, 31, 63, 62, 0, 1, 31, 63, 32'h0);
        tbl[23] = mk(0, 32'h80000000, 31, 63, 62, 1, 0, 0, 0, 32'h80000000);
        tbl[24] = mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[25] = mk(0, 32'h1,  0, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[26] = mk(0, 32'h1,  0, 1, 0, 0, 1, 0, 1, 32'h0);
        tbl[27] = mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0);

        clic_rst = 1'b1; sel_onehot = '0; prio_in_vec = '0; int_thresh = '0; core_int_ack = 1'b0;

        for (int k = 0; k < NV; k++) begin
            clic_rst     = tbl[k].rst;
            sel_onehot   = tbl[k].sel;
            prio_in_vec  = '0;
            prio_in_vec[tbl[k].pidx*PW +: PW] = tbl[k].pval;
            int_thresh   = tbl[k].thr;
            core_int_ack = tbl[k].ack;
            @(posedge clic_clk);
            #1;
            check($sformatf("vec%0d_vld", k), 32'(clic_int_vld), 32'(tbl[k].ev));
            check($sformatf("vec%0d_clr", k), pend_clr_onehot, tbl[k].eclr);
            if (tbl[k].ev || tbl[k].rst) begin
                check($sformatf("vec%0d_id", k), 32'(clic_int_id), 32'(tbl[k].eid));
                check($sformatf("vec%0d_prio", k), 32'(clic_int_prio), 32'(tbl[k].ep));
            end
        end

        // Randomized phase against the reference model
        m_vld = 1'b0; m_id = '0; m_prio = '0; m_clr = '0;
        clic_rst = 1'b1; core_int_ack = 1'b0;
        @(posedge clic_clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            clic_rst = ($urandom_range(0, 63) == 0);
            sel_onehot = '0;
            if ($urandom_range(0, 3) != 0) sel_onehot[$urandom_range(0, N-1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                prio_in_vec[i*PW +: PW] = ($urandom_range(0, 3) == 0) ? PW'(0) : PW'($urandom_range(1, 63));
            end
            int_thresh   = PW'($urandom_range(0, 40));
            core_int_ack = ($urandom_range(0, 2) == 0);
            model_step();
            @(posedge clic_clk);
            #1;
            check("rnd_vld", 32'(clic_int_vld), 32'(m_vld));
            check("rnd_clr", pend_clr_onehot, m_clr);
            if (m_vld || clic_rst) begin
                check("rnd_id", 32'(clic_int_id), 32'(m_id));
                check("rnd_prio", 32'(clic_int_prio), 32'(m_prio));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
